// File: rtl/mop_write_buffer_pkg.sv
// Shared types and defaults for the WSY memory-op write buffer.
// Drain FSM state encoding and default buffer geometry.
package mop_write_buffer_pkg;

    localparam int unsigned MOP_DEPTH_DEF = 4;
    localparam int unsigned MOP_AW_DEF    = 32;
    localparam int unsigned MOP_DW_DEF    = 32;

    typedef enum logic {
        StIdle = 1'b0,
        StReq  = 1'b1
    } mop_state_e;

endpackage

// File: rtl/mop_fifo.sv
// Storage for buffered WSY {address, data} pairs: circular array with pointers and fill count.
// Exposes the read pointer and every slot so the parent can drain the head and scan for forwarding.
module mop_fifo
    import mop_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = MOP_DEPTH_DEF,
    parameter int unsigned AW    = MOP_AW_DEF,
    parameter int unsigned DW    = MOP_DW_DEF,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [PW-1:0] rd_ptr_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW-1:0] ent_addr_o [DEPTH],
    output logic [DW-1:0] ent_data_o [DEPTH]
);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                addr_q[wr_ptr_q] <= push_addr_i;
                data_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign rd_ptr_o   = rd_ptr_q;
    assign count_o    = count_q;
    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign ent_addr_o = addr_q;
    assign ent_data_o = data_q;

endmodule

// File: rtl/mop_write_buffer.sv
// EX-stage write buffer for WSY memory ops: queues {address, data}, drains over req/ack,
// stalls only when full, and forwards the youngest buffered data to a matching load.
module mop_write_buffer
    import mop_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = MOP_DEPTH_DEF,
    parameter int unsigned AW    = MOP_AW_DEF,
    parameter int unsigned DW    = MOP_DW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ex_valid,
    input  logic          mop_en,
    input  logic [AW-1:0] alu_o,
    input  logic [DW-1:0] alu_o2,
    output logic          stall_o,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    output logic          empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    mop_state_e    state_q;
    logic          push, pop, full, empty;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt, scan_idx;
    logic [CW-1:0] count;
    logic [AW-1:0] ent_addr [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];

    // A pop in the same cycle does not release the stall; the WSY retries next cycle.
    assign push    = ex_valid & mop_en & ~full;
    assign stall_o = ex_valid & mop_en & full;
    assign pop     = (state_q == StReq) & mem_ack;
    assign empty_o = empty;

    assign rd_ptr_nxt = rd_ptr + PW'(1);

    mop_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push),
        .push_addr_i (alu_o),
        .push_data_i (alu_o2),
        .pop_i       (pop),
        .rd_ptr_o    (rd_ptr),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .ent_addr_o  (ent_addr),
        .ent_data_o  (ent_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q   <= StReq;
                        mem_req   <= 1'b1;
                        mem_addr  <= ent_addr[rd_ptr];
                        mem_wdata <= ent_data[rd_ptr];
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        // More than the acked entry left: present the next one back-to-back.
                        if (count > CW'(1)) begin
                            mem_addr  <= ent_addr[rd_ptr_nxt];
                            mem_wdata <= ent_data[rd_ptr_nxt];
                        end else begin
                            state_q <= StIdle;
                            mem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        ld_hit   = 1'b0;
        ld_data  = '0;
        scan_idx = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            scan_idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (ent_addr[scan_idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = ent_data[scan_idx];
            end
        end
    end

endmodule

// File: tb/tb_mop_write_buffer.sv
// Directed bench for mop_write_buffer; a scoreboard queue holds expected memory writes in push order.
module tb_mop_write_buffer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ex_valid, mop_en, mem_ack;
    logic [31:0] alu_o, alu_o2, ld_addr;
    logic        stall_o, mem_req, ld_hit, empty_o;
    logic [31:0] mem_addr, mem_wdata, ld_data;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q [$];

    logic        stab_v = 1'b0;
    logic [31:0] stab_addr, stab_data;

    mop_write_buffer #(
        .DEPTH (4),
        .AW    (32),
        .DW    (32)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ex_valid  (ex_valid),
        .mop_en    (mop_en),
        .alu_o     (alu_o),
        .alu_o2    (alu_o2),
        .stall_o   (stall_o),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .empty_o   (empty_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic wsy(input logic [31:0] a, input logic [31:0] d, input bit track);
        ex_valid = 1'b1;
        mop_en   = 1'b1;
        alu_o    = a;
        alu_o2   = d;
        if (track) exp_q.push_back({a, d});
    endtask

    task automatic idle_in;
        ex_valid = 1'b0;
        mop_en   = 1'b0;
    endtask

    task automatic wait_drain;
        bit done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            at_neg;
            if (empty_o && !mem_req) done = 1'b1;
            tick;
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    // Monitor: every accepted request must match the oldest expected write, and a pending
    // request must hold address and data until it is acked.
    always @(negedge clk) begin
        if (!rstn) begin
            stab_v = 1'b0;
        end else begin
            if (mem_req && stab_v) begin
                check("stable_addr", 64'(mem_addr), 64'(stab_addr));
                check("stable_data", 64'(mem_wdata), 64'(stab_data));
            end
            if (mem_req && mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", 64'(mem_addr), 64'(e[63:32]));
                    check("write_data", 64'(mem_wdata), 64'(e[31:0]));
                end
            end
            stab_v    = mem_req && !mem_ack;
            stab_addr = mem_addr;
            stab_data = mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_req;
        rstn = 1'b0; ex_valid = 1'b0; mop_en = 1'b0; mem_ack = 1'b0;
        alu_o = '0; alu_o2 = '0; ld_addr = '0;
        #2;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_ld_hit", 64'(ld_hit), 64'd0);
        check("rst_ld_data", 64'(ld_data), 64'd0);
        #6 rstn = 1'b1;
        tick;

        // Single push, ack two cycles after the request rises.
        wsy(32'h100, 32'hDEAD_BEEF, 1'b1);
        at_neg;
        check("t1_no_req_yet", 64'(mem_req), 64'd0);
        tick;
        idle_in;
        at_neg;
        check("t1_req_latency", 64'(mem_req), 64'd0);
        check("t1_not_empty", 64'(empty_o), 64'd0);
        tick;
        at_neg;
        check("t1_req_up", 64'(mem_req), 64'd1);
        check("t1_addr", 64'(mem_addr), 64'h100);
        tick;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        at_neg;
        check("t1_req_down", 64'(mem_req), 64'd0);
        check("t1_empty", 64'(empty_o), 64'd1);
        tick;

        // Fill with ack held low, then a fifth WSY stalls.
        for (int i = 0; i < 4; i++) begin
            wsy(32'h200 + 32'(i * 4), 32'h10 + 32'(i), 1'b1);
            at_neg;
            check("t2_no_stall", 64'(stall_o), 64'd0);
            tick;
        end
        wsy(32'h300, 32'h55, 1'b0);
        at_neg;
        check("t2_stall_full", 64'(stall_o), 64'd1);
        check("t2_req_held", 64'(mem_req), 64'd1);
        tick;
        mem_ack = 1'b1;
        at_neg;
        check("t2_stall_during_pop", 64'(stall_o), 64'd1);
        tick;
        mem_ack = 1'b0;
        exp_q.push_back({32'h300, 32'h55});
        at_neg;
        check("t2_unstall", 64'(stall_o), 64'd0);
        tick;
        idle_in;
        mem_ack = 1'b1;
        wait_drain;
        mem_ack = 1'b0;
        tick;

        // Back-to-back drain of three entries.
        for (int i = 0; i < 3; i++) begin
            wsy(32'h500 + 32'(i * 8), 32'hA0 + 32'(i), 1'b1);
            tick;
        end
        idle_in;
        mem_ack = 1'b1;
        n_req = 0;
        for (int n = 0; n < 10; n++) begin
            at_neg;
            if (!mem_req) break;
            n_req++;
            tick;
        end
        check("t3_b2b_cycles", 64'(n_req), 64'd3);
        check("t3_req_low", 64'(mem_req), 64'd0);
        tick;
        mem_ack = 1'b0;
        tick;

        // Forwarding: youngest match wins; a push is invisible until the next cycle.
        wsy(32'h40, 32'd1, 1'b1);
        tick;
        wsy(32'h80, 32'd2, 1'b1);
        tick;
        wsy(32'h40, 32'd3, 1'b1);
        ld_addr = 32'h40;
        at_neg;
        check("t4_pre_hit", 64'(ld_hit), 64'd1);
        check("t4_pre_data", 64'(ld_data), 64'd1);
        tick;
        idle_in;
        at_neg;
        check("t4_hit", 64'(ld_hit), 64'd1);
        check("t4_youngest", 64'(ld_data), 64'd3);
        tick;
        ld_addr = 32'h80;
        at_neg;
        check("t4_mid_data", 64'(ld_data), 64'd2);
        tick;
        ld_addr = 32'hC0;
        at_neg;
        check("t4_miss_hit", 64'(ld_hit), 64'd0);
        check("t4_miss_data", 64'(ld_data), 64'd0);
        tick;
        mem_ack = 1'b1;
        wait_drain;
        mem_ack = 1'b0;
        ld_addr = 32'h40;
        at_neg;
        check("t4_drained_miss", 64'(ld_hit), 64'd0);
        tick;

        // Reset while a request is pending: both entries are discarded.
        wsy(32'h700, 32'h77, 1'b0);
        tick;
        wsy(32'h704, 32'h78, 1'b0);
        tick;
        idle_in;
        at_neg;
        check("t5_req_before", 64'(mem_req), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("t5_req_async", 64'(mem_req), 64'd0);
        check("t5_empty", 64'(empty_o), 64'd1);
        #1 rstn = 1'b1;
        tick;
        for (int n = 0; n < 5; n++) begin
            at_neg;
            check("t5_no_req", 64'(mem_req), 64'd0);
            tick;
        end

        // Non-WSY traffic and stray acks must leave the buffer untouched.
        for (int n = 0; n < 10; n++) begin
            ex_valid = 1'b1;
            mop_en   = 1'b0;
            alu_o    = $urandom;
            alu_o2   = $urandom;
            mem_ack  = 1'($urandom_range(0, 1));
            at_neg;
            check("t6_no_stall", 64'(stall_o), 64'd0);
            check("t6_no_req", 64'(mem_req), 64'd0);
            tick;
        end
        ex_valid = 1'b0;
        mop_en   = 1'b1;
        mem_ack  = 1'b0;
        at_neg;
        check("t6_bubble_no_stall", 64'(stall_o), 64'd0);
        tick;
        mop_en = 1'b0;
        at_neg;
        check("t6_empty", 64'(empty_o), 64'd1);
        check("sb_all_written", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
